// File: rtl/lut_fetch_pkg.sv
// Shared types, table IDs and address helper for the LUT fetch sequencer.
package lut_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PUSH,
    S_FLUSH
  } state_t;

  localparam logic [7:0] CLASSIFIER_BS = 8'h01;
  localparam logic [7:0] CLASSIFIER_WT = 8'h02;
  localparam logic [7:0] EMBED_BS      = 8'h03;
  localparam logic [7:0] EMBED_WT      = 8'h04;
  localparam logic [7:0] ATTN_Q_BS     = 8'h05;
  localparam logic [7:0] ATTN_Q_WT     = 8'h06;
  localparam logic [7:0] ATTN_K_BS     = 8'h07;
  localparam logic [7:0] ATTN_K_WT     = 8'h08;
  localparam logic [7:0] ATTN_V_BS     = 8'h09;
  localparam logic [7:0] ATTN_V_WT     = 8'h0A;
  localparam logic [7:0] ATTN_O_BS     = 8'h0B;
  localparam logic [7:0] ATTN_O_WT     = 8'h0C;
  localparam logic [7:0] MLP1_BS       = 8'h0D;
  localparam logic [7:0] MLP1_WT       = 8'h0E;
  localparam logic [7:0] MLP2_BS       = 8'h0F;
  localparam logic [7:0] MLP2_WT       = 8'h10;
  localparam logic [7:0] PS_BS         = 8'h11;
  localparam logic [7:0] PS_WT         = 8'h12;

  // Table ID sits directly above the index; caller truncates to its width.
  function automatic logic [63:0] make_addr(
    input logic [7:0]  tbl,
    input logic [55:0] idx,
    input int unsigned idx_w
  );
    make_addr = ({56'd0, tbl} << idx_w) | {8'd0, idx};
  endfunction

endpackage

// File: rtl/lut_fetch_seq_pack.sv
// Lane packing register: writes one element per lane, holds until cleared.
module lut_pack_reg
  import lut_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int PW         = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        wr,
  input  logic [PW-1:0]               lane,
  input  logic [DATA_WIDTH-1:0]       wdata,
  output logic [LANES*DATA_WIDTH-1:0] data,
  output logic [LANES-1:0]            keep
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data <= '0;
      keep <= '0;
    end else if (wr) begin
      data[lane*DATA_WIDTH +: DATA_WIDTH] <= wdata;
      keep[lane] <= 1'b1;
    end
  end

endmodule

// File: rtl/lut_fetch_seq.sv
// LUT fetch sequencer: one LUT read per element, packed onto a valid/ready stream.
// Optional done-wait timeout enabled by LUT_FETCH_TIMEOUT_EN.
module lut_fetch_seq
  import lut_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int LANES       = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [7:0]                  job_table,
  input  logic [ADDR_WIDTH-9:0]       job_index,
  input  logic [CNT_WIDTH-1:0]        job_count,
  output logic                        lut_start,
  output logic [ADDR_WIDTH-1:0]       lut_addr,
  input  logic [DATA_WIDTH-1:0]       lut_data,
  input  logic                        lut_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [LANES-1:0]            out_keep,
  output logic                        out_last,
  output logic                        busy,
  output logic                        err
);

  localparam int IW = ADDR_WIDTH - 8;
  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned IWU = IW;

  state_t state_q, state_d;

  logic [7:0]           tbl_q;
  logic [IW-1:0]        idx_q;
  logic [CNT_WIDTH-1:0] rem_q;
  logic [PW-1:0]        ptr_q;
  logic                 last_q;

  logic take_job, elem_done, hs;
  logic word_full, last_elem, tmo_hit;
  logic [DATA_WIDTH-1:0] wdata;

  assign take_job  = (state_q == S_IDLE) && job_valid;
  assign out_valid = (state_q == S_PUSH) || (state_q == S_FLUSH);
  assign hs        = out_valid && out_ready;
  assign elem_done = (state_q == S_WAIT) && (lut_done || tmo_hit);
  assign word_full = (ptr_q == PW'(LANES - 1));
  assign last_elem = (rem_q == CNT_WIDTH'(1));
  assign wdata     = lut_done ? lut_data : '0;

  assign job_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign lut_start = (state_q == S_REQ);
  assign out_last  = last_q;
  assign lut_addr  = ADDR_WIDTH'(make_addr(tbl_q, 56'(idx_q), IWU));

`ifdef LUT_FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;

  assign tmo_hit = (state_q == S_WAIT) && !lut_done
                && (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_WAIT && !lut_done && !tmo_hit)
        tmo_q <= tmo_q + TW'(1);
      else
        tmo_q <= '0;
      if (tmo_hit)
        err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (take_job)
          state_d = (job_count == '0) ? S_FLUSH : S_REQ;
      S_REQ:
        state_d = S_WAIT;
      S_WAIT:
        if (elem_done)
          state_d = (word_full || last_elem) ? S_PUSH : S_REQ;
      S_PUSH:
        if (hs)
          state_d = (rem_q != '0) ? S_REQ : S_IDLE;
      S_FLUSH:
        if (hs)
          state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_q  <= '0;
      idx_q  <= '0;
      rem_q  <= '0;
      ptr_q  <= '0;
      last_q <= 1'b0;
    end else if (take_job) begin
      tbl_q  <= job_table;
      idx_q  <= job_index;
      rem_q  <= job_count;
      ptr_q  <= '0;
      last_q <= (job_count == '0);
    end else if (elem_done) begin
      idx_q  <= idx_q + IW'(1);
      rem_q  <= rem_q - CNT_WIDTH'(1);
      ptr_q  <= word_full ? '0 : ptr_q + PW'(1);
      last_q <= last_elem;
    end else if (hs) begin
      ptr_q  <= '0;
      last_q <= 1'b0;
    end
  end

  lut_pack_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .LANES     (LANES),
    .PW        (PW)
  ) u_pack (
    .clk  (clk),
    .rst  (rst),
    .clr  (hs || take_job),
    .wr   (elem_done),
    .lane (ptr_q),
    .wdata(wdata),
    .data (out_data),
    .keep (out_keep)
  );

endmodule

// File: tb/tb_lut_fetch_seq.sv
// Directed bench for lut_fetch_seq with a fixed-latency LUT model.
module tb_lut_fetch_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [7:0]  job_table = '0;
  logic [23:0] job_index = '0;
  logic [15:0] job_count = '0;
  logic        lut_start;
  logic [31:0] lut_addr;
  logic [7:0]  lut_data = '0;
  logic        lut_done = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        busy;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lut_fetch_seq dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_table(job_table), .job_index(job_index),
    .job_count(job_count),
    .lut_start(lut_start), .lut_addr(lut_addr),
    .lut_data(lut_data), .lut_done(lut_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .busy(busy), .err(err)
  );

  // LUT model: answers addr[7:0]+0x10 three cycles after each start.
  bit          model_en = 1'b1;
  bit          pend = 1'b0;
  int          cnt = 0;
  int          start_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] addr_q[$];

  always @(negedge clk) begin
    if (model_en && lut_done) lut_done = 1'b0;
    if (lut_start) begin
      start_cnt++;
      addr_q.push_back(lut_addr);
      pend = 1'b1;
      cnt = 3;
      pend_addr = lut_addr;
    end else if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend = 1'b0;
        if (model_en) begin
          lut_done = 1'b1;
          lut_data = pend_addr[7:0] + 8'h10;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_job(input logic [7:0] t, input logic [23:0] i,
                          input logic [15:0] c);
    step();
    job_table = t;
    job_index = i;
    job_count = c;
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
  endtask

  task automatic get_word(input int stall, input int bound,
                          output logic [31:0] d, output logic [3:0] k,
                          output logic l, output int stall_starts,
                          output bit got);
    int s0;
    got = 1'b0;
    d = '0; k = '0; l = 1'b0; stall_starts = 0;
    for (int i = 0; i < bound; i++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL word_timeout: out_valid never rose within %0d cycles", bound);
    end else begin
      s0 = start_cnt;
      repeat (stall) step();
      stall_starts = start_cnt - s0;
      d = out_data;
      k = out_keep;
      l = out_last;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({job_ready, busy, out_valid, lut_start, out_last, err} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 100000",
               {job_ready, busy, out_valid, lut_start, out_last, err});
    end
    checks++;
    if (lut_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr: got %h want 00000000", lut_addr);
    end
    checks++;
    if ({out_data, out_keep} !== 36'h0) begin
      failures++;
      $display("FAIL reset_data: got %h/%h want 0/0", out_data, out_keep);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [3:0] k; logic l; int ss; bit got;
    logic [31:0] exp_addr;
    int s0;
    addr_q.delete();
    s0 = start_cnt;
    send_job(8'h02, 24'h0, 16'd4);
    get_word(0, 200, d, k, l, ss, got);
    checks++;
    if ({d, k, l} !== {32'h13121110, 4'hF, 1'b1}) begin
      failures++;
      $display("FAIL basic_word: got %h/%h/%b want 13121110/f/1", d, k, l);
    end
    checks++;
    if (start_cnt - s0 != 4) begin
      failures++;
      $display("FAIL basic_starts: got %0d want 4", start_cnt - s0);
    end
    for (int i = 0; i < 4; i++) begin
      exp_addr = 32'h02000000 + 32'(i);
      checks++;
      if (addr_q.size() <= i || addr_q[i] !== exp_addr) begin
        failures++;
        $display("FAIL basic_addr%0d: got %h want %h", i,
                 (addr_q.size() > i) ? addr_q[i] : 32'hx, exp_addr);
      end
    end
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle: got ready=%b busy=%b want 1/0", job_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [3:0] k; logic l; int ss; bit got;
    int s0;
    s0 = start_cnt;
    send_job(8'h03, 24'h10, 16'd6);
    get_word(10, 200, d, k, l, ss, got);
    checks++;
    if (ss != 0) begin
      failures++;
      $display("FAIL bp_stall_starts: got %0d want 0", ss);
    end
    checks++;
    if ({d, k, l} !== {32'h23222120, 4'hF, 1'b0}) begin
      failures++;
      $display("FAIL bp_word0: got %h/%h/%b want 23222120/f/0", d, k, l);
    end
    get_word(0, 200, d, k, l, ss, got);
    checks++;
    if ({d, k, l} !== {32'h00002524, 4'b0011, 1'b1}) begin
      failures++;
      $display("FAIL bp_word1: got %h/%h/%b want 00002524/3/1", d, k, l);
    end
    checks++;
    if (start_cnt - s0 != 6) begin
      failures++;
      $display("FAIL bp_starts: got %0d want 6", start_cnt - s0);
    end
  endtask

  task automatic test_zero_count();
    logic [31:0] d; logic [3:0] k; logic l; int ss; bit got;
    int s0;
    s0 = start_cnt;
    send_job(8'h04, 24'h55, 16'd0);
    checks++;
    if (job_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_ready_busy: got %b want 0", job_ready);
    end
    get_word(0, 50, d, k, l, ss, got);
    checks++;
    if ({d, k, l} !== {32'h0, 4'h0, 1'b1}) begin
      failures++;
      $display("FAIL zero_word: got %h/%h/%b want 0/0/1", d, k, l);
    end
    checks++;
    if (start_cnt != s0) begin
      failures++;
      $display("FAIL zero_starts: got %0d want 0", start_cnt - s0);
    end
    checks++;
    if (job_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_ready_after: got %b want 1", job_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [3:0] k; logic l; int ss; bit got;
    int s0;
    bit seen;
    s0 = start_cnt;
    seen = 1'b0;
    send_job(8'h05, 24'h0, 16'd4);
    for (int i = 0; i < 100; i++) begin
      if (start_cnt - s0 == 3) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    model_en = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rstmid_reach: got %0d starts want 3", start_cnt - s0);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    lut_done = 1'b1;
    lut_data = 8'hAA;
    step();
    lut_done = 1'b0;
    step();
    checks++;
    if ({job_ready, busy, out_valid, out_last, lut_start} !== 5'b10000) begin
      failures++;
      $display("FAIL rstmid_ctrl: got %b want 10000",
               {job_ready, busy, out_valid, out_last, lut_start});
    end
    checks++;
    if ({lut_addr, out_data, out_keep} !== 68'h0) begin
      failures++;
      $display("FAIL rstmid_regs: got %h/%h/%h want 0/0/0",
               lut_addr, out_data, out_keep);
    end
    repeat (4) step();
    model_en = 1'b1;
    send_job(8'h04, 24'h20, 16'd2);
    get_word(0, 200, d, k, l, ss, got);
    checks++;
    if ({d, k, l} !== {32'h00003130, 4'b0011, 1'b1}) begin
      failures++;
      $display("FAIL rstmid_next: got %h/%h/%b want 00003130/3/1", d, k, l);
    end
  endtask

  task automatic test_index_wrap();
    logic [31:0] d; logic [3:0] k; logic l; int ss; bit got;
    addr_q.delete();
    send_job(8'h09, 24'hFFFFFF, 16'd2);
    get_word(0, 200, d, k, l, ss, got);
    checks++;
    if (addr_q.size() != 2) begin
      failures++;
      $display("FAIL wrap_nreq: got %0d want 2", addr_q.size());
    end else begin
      checks++;
      if (addr_q[0] !== 32'h09FFFFFF) begin
        failures++;
        $display("FAIL wrap_addr0: got %h want 09ffffff", addr_q[0]);
      end
      checks++;
      if (addr_q[1] !== 32'h09000000) begin
        failures++;
        $display("FAIL wrap_addr1: got %h want 09000000", addr_q[1]);
      end
    end
    checks++;
    if ({d, k, l} !== {32'h0000100F, 4'b0011, 1'b1}) begin
      failures++;
      $display("FAIL wrap_word: got %h/%h/%b want 0000100f/3/1", d, k, l);
    end
  endtask

`ifdef LUT_FETCH_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] d; logic [3:0] k; logic l; int ss; bit got;
    int s0;
    s0 = start_cnt;
    send_job(8'h06, 24'h40, 16'd2);
    for (int i = 0; i < 100; i++) begin
      if (start_cnt - s0 == 2) break;
      step();
    end
    model_en = 1'b0;
    get_word(0, 300, d, k, l, ss, got);
    checks++;
    if ({d, k, l} !== {32'h00000050, 4'b0011, 1'b1}) begin
      failures++;
      $display("FAIL tmo_word: got %h/%h/%b want 00000050/3/1", d, k, l);
    end
    repeat (10) step();
    model_en = 1'b1;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_err_sticky: got %b want 1", err);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_err_clear: got %b want 0", err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_reset_mid();
    test_index_wrap();
`ifdef LUT_FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lut_fetch_seq.md
Name: lut_fetch_seq

Overview:
- Requester-side sequencer for the weight/bias LUT block's start/addr -> data_o/done interface.
- Accepts a fetch job (table ID, first element index, element count) and issues one LUT read per element, waiting for done each time.
- Packs the returned bytes into wide words and presents them on a valid/ready stream to downstream compute (embedding, attention, MLP, classifier).

Parameters:
- ADDR_WIDTH, 32, LUT address width; addr = {table_id[7:0], index[ADDR_WIDTH-9:0]}
- DATA_WIDTH, 8, LUT data width (one element)
- LANES, 4, elements packed per output word
- CNT_WIDTH, 16, width of the element count
- TIMEOUT_CYC, 64, done-wait limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- job_valid  in  1  job request
- job_ready  out  1  high only in IDLE
- job_table  in  8  table ID (0x01..0x12)
- job_index  in  ADDR_WIDTH-8  first element index
- job_count  in  CNT_WIDTH  element count; 0 is legal
- lut_start  out  1  one-cycle request pulse to LUT
- lut_addr  out  ADDR_WIDTH  LUT address, held stable from start until done
- lut_data  in  DATA_WIDTH  LUT read data, sampled on the cycle lut_done=1
- lut_done  in  1  LUT completion pulse
- out_valid  out  1  packed word valid
- out_ready  in  1  downstream accept
- out_data  out  LANES*DATA_WIDTH  packed word; lane 0 = lowest element index, in LSBs
- out_keep  out  LANES  per-lane valid mask
- out_last  out  1  final word of job
- busy  out  1  job in progress
- err  out  1  sticky timeout flag; tied 0 when feature off

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - State -> IDLE.
  - lut_start=0, lut_addr=0, out_valid=0, out_data=0, out_keep=0, out_last=0, busy=0, err=0, job_ready=1 (IDLE).
  - rst mid-job abandons the job immediately; a late lut_done after reset is ignored.
- States: IDLE, REQ, WAIT, PUSH, FLUSH.
- IDLE:
  - On job_valid&&job_ready, latch table, index and count; clear lane pointer.
  - count=0: go to FLUSH with out_keep=0 and out_last=1, so exactly one empty last word is emitted.
  - count>0: go to REQ.
- REQ:
  - Assert lut_start for exactly one cycle; lut_addr = {table, cur_index}.
  - Next state WAIT.
- WAIT:
  - Hold lut_addr; lut_start=0.
  - On lut_done: write lut_data into lane[ptr], set keep[ptr], increment ptr, cur_index, and issued count.
  - Word full (ptr wraps at LANES) or last element reached: go to PUSH.
  - Otherwise: go to REQ. Minimum spacing between start pulses is 2 cycles.
  - A lut_done in any state other than WAIT is ignored.
- PUSH:
  - out_valid=1; out_data, out_keep and out_last stay stable until out_ready.
  - On the handshake: clear the pack register and keep; ptr=0.
  - If elements remain, go to REQ in the same cycle (no bubble beyond the FSM hop); else go to IDLE.
  - No LUT request is issued while a word is pending (backpressure stalls the LUT).
- FLUSH: same as PUSH for the empty word, then IDLE.
- Last word:
  - out_last=1 on the word containing element count-1.
  - Unused upper lanes are zero, with keep bits 0 (e.g., count=6, LANES=4: second word keep=4'b0011).
- Index arithmetic: cur_index wraps modulo 2^(ADDR_WIDTH-8); no carry into table_id.
- busy = (state != IDLE).
- job_valid while busy is not accepted; the requester holds it.

Optional Feature:
- Macro: LUT_FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYC cycles pass without lut_done: err set (sticky until rst), the current element is written as 0 with keep=1, and the sequence continues.
  - A late done for the timed-out request is ignored.
- Undefined: no counter; WAIT waits forever; err tied 0.

Decomposition:
- Package lut_fetch_pkg:
  - state enum typedef.
  - Table ID localparams (CLASSIFIER_BS=8'h01 ... PS_WT=8'h12).
  - Address-concatenation function.
- Sub-module lut_pack_reg: lane write/clear/keep logic with hold-until-ready output register.

Test Plan:
- job table=0x02, index=0, count=4; LUT model returns idx+0x10 after 3 cycles -> lut_addr 0x02000000..0x02000003; one word out_data=0x13121110, keep=4'hF, last=1.
- count=6, out_ready held 0 for 10 cycles on first word -> no lut_start during stall; second word keep=4'b0011, last=1; total lut_start pulses=6.
- count=0 -> single word, keep=0, last=1, zero lut_start pulses; job_ready returns after handshake.
- rst asserted in WAIT of element 2; done pulsed one cycle later -> all outputs at reset values, no out_valid, next job starts clean.
- index=0xFFFFFF, count=2, table=0x09 -> addresses 0x09FFFFFF then 0x09000000.
- LUT_FETCH_TIMEOUT_EN defined, LUT never answers element 1 of count=2 -> after 64 WAIT cycles err=1, out_data lane1=0 with keep=4'b0011; err stays 1 until rst.
